// File: rtl/data_ram_if.sv
// MEM-stage data-memory bus between the load/store requester and the RAM responder.
// DRAM_RANGE_CHECK_EN adds the mem_err_o response flag.
interface data_ram_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
`ifdef DRAM_RANGE_CHECK_EN
  logic        mem_err_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    input  mem_data_o, mem_ready_o, mem_err_o
  );
  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    output mem_data_o, mem_ready_o, mem_err_o
  );
`else
  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    input  mem_data_o, mem_ready_o
  );
  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    output mem_data_o, mem_ready_o
  );
`endif
endinterface

// File: rtl/data_ram_responder.sv
// Word-wide data RAM responder with programmable wait states and a one-cycle ready pulse.
// Optional DRAM_RANGE_CHECK_EN rejects out-of-range addresses and flags them on mem_err_o.
module data_ram_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  data_ram_if.slave   bus
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SEL_W     = DATA_W / 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                we_q;
  logic [SEL_W-1:0]    sel_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                req_err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;

  logic [DATA_W-1:0]   ram [DEPTH];

  logic                req_err_c;
  logic                acc_fire_c;
  logic                acc_we_c;
  logic [SEL_W-1:0]    acc_sel_c;
  logic [ADDR_W-1:0]   acc_idx_c;
  logic [DATA_W-1:0]   acc_data_c;
  logic                acc_err_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{bus.mem_addr_i[31:ADDR_W+2], bus.mem_addr_i[1:0]};

`ifdef DRAM_RANGE_CHECK_EN
  logic err_q;
  assign req_err_c   = (bus.mem_addr_i[31:ADDR_W+2] != '0);
  assign bus.mem_err_o = err_q;
`else
  assign req_err_c   = 1'b0;
`endif

  // Access-edge request: live inputs on a zero-wait accept, latched fields otherwise.
  always_comb begin
    acc_fire_c = 1'b0;
    acc_we_c   = we_q;
    acc_sel_c  = sel_q;
    acc_idx_c  = idx_q;
    acc_data_c = wdata_q;
    acc_err_c  = req_err_q;
    unique case (state)
      S_IDLE: begin
        if (ZERO_WAIT && bus.mem_ce_i) begin
          acc_fire_c = 1'b1;
          acc_we_c   = bus.mem_we_i;
          acc_sel_c  = bus.mem_sel_i;
          acc_idx_c  = bus.mem_addr_i[ADDR_W+1:2];
          acc_data_c = bus.mem_data_i;
          acc_err_c  = req_err_c;
        end
      end
      S_WAIT:  acc_fire_c = bus.mem_ce_i && (cnt == CNT_W'(1));
      default: acc_fire_c = 1'b0;
    endcase
  end

  assign rd_word_c = ram[acc_idx_c];

  // Array has no reset; a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && acc_fire_c && acc_we_c && !acc_err_c) begin
      for (int k = 0; k < int'(SEL_W); k++) begin
        if (acc_sel_c[k]) ram[acc_idx_c][8*k +: 8] <= acc_data_c[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      req_err_q <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
`ifdef DRAM_RANGE_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef DRAM_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (bus.mem_ce_i) begin
            we_q      <= bus.mem_we_i;
            sel_q     <= bus.mem_sel_i;
            idx_q     <= bus.mem_addr_i[ADDR_W+1:2];
            wdata_q   <= bus.mem_data_i;
            req_err_q <= req_err_c;
            cnt       <= CNT_W'(WAIT_CYCLES);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.mem_ce_i) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      // The access edge overrides the state update above.
      if (acc_fire_c) begin
        state   <= S_RESP;
        ready_q <= 1'b1;
        rdata_q <= (acc_we_c || acc_err_c) ? '0 : rd_word_c;
`ifdef DRAM_RANGE_CHECK_EN
        err_q   <= acc_err_c;
`endif
      end
    end
  end

  assign bus.mem_data_o  = rdata_q;
  assign bus.mem_ready_o = ready_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: vector table, corner sequences, randomized model check.
module tb_data_ram_responder;
  localparam int unsigned ADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        use0;
  logic        ce;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;

  int errors = 0;
  int checks = 0;

  data_ram_if if2();
  data_ram_if if0();

  assign if2.mem_ce_i   = ce & ~use0;
  assign if2.mem_we_i   = we;
  assign if2.mem_sel_i  = sel;
  assign if2.mem_addr_i = addr;
  assign if2.mem_data_i = wdata;
  assign if0.mem_ce_i   = ce & use0;
  assign if0.mem_we_i   = we;
  assign if0.mem_sel_i  = sel;
  assign if0.mem_addr_i = addr;
  assign if0.mem_data_i = wdata;

  data_ram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  data_ram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  wire        ready = use0 ? if0.mem_ready_o : if2.mem_ready_o;
  wire [31:0] rdata = use0 ? if0.mem_data_o  : if2.mem_data_o;
`ifdef DRAM_RANGE_CHECK_EN
  wire        err   = use0 ? if0.mem_err_o   : if2.mem_err_o;
`else
  wire        err   = 1'b0;
`endif

  typedef struct {
    bit          d0;
    bit          w;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  // One complete request; returns response data, cycles from accept edge to visible ready, err flag.
  task automatic do_req(input bit d0, input bit w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat, output logic er);
    @(negedge clk);
    use0 = d0; ce = 1'b1; we = w; sel = s; addr = a; wdata = d;
    lat = 0; rd = 'x; er = 1'bx;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 40);
    if (!ready) begin
      checks++; errors++;
      $display("FAIL req_timeout actual=no_ready required=ready addr=%h", a);
    end else begin
      rd = rdata;
      er = err;
    end
    ce = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", 32'(ready), 32'd0);
  endtask

  logic [31:0] mdl [2][16];
  vec_t        vt[$];

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        er;
    bit          seen;
    logic [5:0]  pat;
    int          k;

    use0 = 1'b0; ce = 1'b0; we = 1'b0; sel = '0; addr = '0; wdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready2", 32'(if2.mem_ready_o), 32'd0);
    chk("rst_data2",  if2.mem_data_o, 32'd0);
    chk("rst_ready0", 32'(if0.mem_ready_o), 32'd0);
    chk("rst_data0",  if0.mem_data_o, 32'd0);
    rst = 1'b0;

    // Vector table
    vt.push_back('{0, 1, 4'hF, 32'h40, 32'h12345678, 32'h0,        3});
    vt.push_back('{0, 0, 4'hF, 32'h40, 32'h0,        32'h12345678, 3});
    vt.push_back('{0, 1, 4'h8, 32'h40, 32'hAAAAAAAA, 32'h0,        3});
    vt.push_back('{0, 0, 4'h0, 32'h40, 32'h0,        32'hAA345678, 3});
    vt.push_back('{0, 1, 4'h1, 32'h40, 32'h000000BB, 32'h0,        3});
    vt.push_back('{0, 0, 4'hF, 32'h43, 32'h0,        32'hAA3456BB, 3});
    vt.push_back('{0, 1, 4'hF, 32'h44, 32'h0000CAFE, 32'h0,        3});
    vt.push_back('{0, 1, 4'h0, 32'h44, 32'hFFFFFFFF, 32'h0,        3});
    vt.push_back('{0, 0, 4'hF, 32'h44, 32'h0,        32'h0000CAFE, 3});
    vt.push_back('{1, 1, 4'hF, 32'h40, 32'h87654321, 32'h0,        1});
    vt.push_back('{1, 1, 4'h6, 32'h41, 32'h00FFFF00, 32'h0,        1});
    vt.push_back('{1, 0, 4'hF, 32'h40, 32'h0,        32'h87FFFF21, 1});
    foreach (vt[i]) begin
      do_req(vt[i].d0, vt[i].w, vt[i].sel, vt[i].addr, vt[i].wd, rd, lat, er);
      chk($sformatf("vec%0d_data", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_err", i), 32'(er), 32'd0);
    end

    // Reset during WAIT abandons the write
    do_req(0, 1, 4'hF, 32'h10, 32'h11111111, rd, lat, er);
    do_req(0, 0, 4'hF, 32'h10, 32'h0, rd, lat, er);
    chk("rstw_pre_read", rd, 32'h11111111);
    @(negedge clk);
    use0 = 1'b0; ce = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h10; wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rstw_no_ready_wait", 32'(ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_no_ready_rst", 32'(ready), 32'd0);
    chk("rstw_data_cleared", rdata, 32'd0);
    rst = 1'b0; ce = 1'b0;
    do_req(0, 0, 4'hF, 32'h10, 32'h0, rd, lat, er);
    chk("rstw_read_old", rd, 32'h11111111);

    // Abort after one WAIT cycle
    do_req(0, 1, 4'hF, 32'h80, 32'h0BADF00D, rd, lat, er);
    @(negedge clk);
    use0 = 1'b0; ce = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h80; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    ce = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    chk("abort_no_ready", 32'(seen), 32'd0);
    do_req(0, 0, 4'hF, 32'h80, 32'h0, rd, lat, er);
    chk("abort_read_old", rd, 32'h0BADF00D);

    // Back-to-back reads with zero wait states
    do_req(1, 1, 4'hF, 32'h0, 32'hA0A0A0A0, rd, lat, er);
    do_req(1, 1, 4'hF, 32'h4, 32'hB1B1B1B1, rd, lat, er);
    do_req(1, 1, 4'hF, 32'h8, 32'hC2C2C2C2, rd, lat, er);
    @(negedge clk);
    use0 = 1'b1; ce = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h0;
    pat = '0; k = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pat = {pat[4:0], ready};
      if (ready) begin
        case (k)
          0: chk("b2b_word0", rdata, 32'hA0A0A0A0);
          1: chk("b2b_word1", rdata, 32'hB1B1B1B1);
          default: chk("b2b_word2", rdata, 32'hC2C2C2C2);
        endcase
        k++;
        if (k < 3) addr = 32'(k * 4);
        else ce = 1'b0;
      end
    end
    chk("b2b_ready_pattern", 32'(pat), 32'b101010);
    chk("b2b_count", 32'(k), 32'd3);

`ifdef DRAM_RANGE_CHECK_EN
    do_req(0, 1, 4'hF, 32'h0, 32'h01020304, rd, lat, er);
    do_req(0, 1, 4'hF, 32'h1 << (ADDR_W + 2), 32'h55, rd, lat, er);
    chk("range_wr_err", 32'(er), 32'd1);
    chk("range_wr_data", rd, 32'd0);
    do_req(0, 0, 4'hF, 32'h0, 32'h0, rd, lat, er);
    chk("range_word0_kept", rd, 32'h01020304);
    chk("range_word0_err", 32'(er), 32'd0);
    do_req(0, 0, 4'hF, 32'h1 << (ADDR_W + 2), 32'h0, rd, lat, er);
    chk("range_rd_err", 32'(er), 32'd1);
    chk("range_rd_data", rd, 32'd0);
`else
    do_req(1, 1, 4'hF, 32'h4 | (32'h1 << (ADDR_W + 2)), 32'h5A5A0004, rd, lat, er);
    do_req(1, 0, 4'hF, 32'h4, 32'h0, rd, lat, er);
    chk("alias_read", rd, 32'h5A5A0004);
    do_req(0, 1, 4'hF, 32'h8 | (32'h3 << (ADDR_W + 2)), 32'h77665544, rd, lat, er);
    do_req(0, 0, 4'hF, 32'h8, 32'h0, rd, lat, er);
    chk("alias_read_w2", rd, 32'h77665544);
`endif

    // Randomized traffic against a word-array model
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        mdl[d][i] = $urandom;
        do_req(d[0], 1, 4'hF, 32'(i * 4), mdl[d][i], rd, lat, er);
      end
    end
    for (int n = 0; n < 80; n++) begin
      bit          d0;
      bit          w;
      logic [3:0]  s;
      int          idx;
      logic [31:0] a;
      logic [31:0] dv;
      d0  = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      s   = 4'($urandom);
      idx = $urandom_range(0, 15);
      dv  = $urandom;
      a   = 32'(idx * 4) | 32'($urandom_range(0, 3));
`ifndef DRAM_RANGE_CHECK_EN
      a   = a | (32'($urandom_range(0, 7)) << (ADDR_W + 2));
`endif
      do_req(d0, w, s, a, dv, rd, lat, er);
      if (w) begin
        mdl[int'(d0)][idx] = merge(mdl[int'(d0)][idx], dv, s);
        chk($sformatf("rnd%0d_wr_data", n), rd, 32'd0);
      end else begin
        chk($sformatf("rnd%0d_rd_data", n), rd, mdl[int'(d0)][idx]);
      end
      chk($sformatf("rnd%0d_lat", n), 32'(lat), d0 ? 32'd1 : 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
